// File: rtl/vga_timing_pkg.sv
// Shared constants and elaboration-time helpers for the VGA raster timing generator.
package vga_timing_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FRONT  = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BACK   = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FRONT  = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BACK   = 33;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned axis_total(input int unsigned active, input int unsigned front,
                                               input int unsigned sync, input int unsigned back);
        return active + front + sync + back;
    endfunction

    function automatic int unsigned sync_start(input int unsigned active, input int unsigned front);
        return active + front;
    endfunction

    function automatic int unsigned sync_end(input int unsigned active, input int unsigned front,
                                             input int unsigned sync);
        return active + front + sync;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping 0..TOTAL-1 counter used for both raster axes; wrap flags the incrementing terminal count.
module vga_axis_counter #(
    parameter int unsigned TOTAL = 800,
    parameter int unsigned CW    = 10
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          inc,
    input  logic          clear,
    output logic [CW-1:0] cnt,
    output logic          wrap
);

    assign wrap = inc && (cnt == CW'(TOTAL - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= wrap ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel divider, h/v counters and a registered decode stage.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT  = DEF_H_FRONT,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BACK   = DEF_H_BACK,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT  = DEF_V_FRONT,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BACK   = DEF_V_BACK,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned PIX_DIV  = 1,
    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK),
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK),
    localparam int unsigned CW      = clog2(max_u(H_TOTAL, V_TOTAL))
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          enable,
    input  logic          restart,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          de,
    output logic          blank_n,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start,
    output logic          pix_tick
);

    localparam int unsigned DW       = (PIX_DIV > 1) ? clog2(PIX_DIV) : 1;
    localparam int unsigned HS_START = sync_start(H_ACTIVE, H_FRONT);
    localparam int unsigned HS_END   = sync_end(H_ACTIVE, H_FRONT, H_SYNC);
    localparam int unsigned VS_START = sync_start(V_ACTIVE, V_FRONT);
    localparam int unsigned VS_END   = sync_end(V_ACTIVE, V_FRONT, V_SYNC);

    logic [DW-1:0] div;
    logic          tick;
    logic          h_wrap;
    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    int unsigned   h_u;
    int unsigned   v_u;
    logic          de_d;
    logic          hs_act;
    logic          vs_act;

    assign tick = enable && (div == DW'(PIX_DIV - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div <= '0;
        end else if (restart) begin
            div <= '0;
        end else if (enable) begin
            div <= tick ? '0 : div + DW'(1);
        end
    end

    vga_axis_counter #(.TOTAL(H_TOTAL), .CW(CW)) u_h_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (tick),
        .clear  (restart),
        .cnt    (h_cnt),
        .wrap   (h_wrap)
    );

    vga_axis_counter #(.TOTAL(V_TOTAL), .CW(CW)) u_v_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (h_wrap),
        .clear  (restart),
        .cnt    (v_cnt),
        .wrap   ()
    );

    // Compare in 32 bits so sync end values equal to a power-of-two total cannot alias.
    always_comb begin
        h_u    = 32'(h_cnt);
        v_u    = 32'(v_cnt);
        de_d   = (h_u < H_ACTIVE) && (v_u < V_ACTIVE);
        hs_act = (h_u >= HS_START) && (h_u < HS_END);
        vs_act = (v_u >= VS_START) && (v_u < VS_END);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x           <= '0;
            y           <= '0;
            de          <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            pix_tick    <= 1'b0;
        end else if (restart) begin
            x           <= '0;
            y           <= '0;
            de          <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            pix_tick    <= 1'b0;
        end else begin
            pix_tick    <= tick;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (tick) begin
                x           <= h_cnt;
                y           <= v_cnt;
                de          <= de_d;
                hsync       <= hs_act ? HS_POL : ~HS_POL;
                vsync       <= vs_act ? VS_POL : ~VS_POL;
                line_start  <= (h_cnt == '0);
                frame_start <= (h_cnt == '0) && (v_cnt == '0);
            end
        end
    end

    assign blank_n = de;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on two small rasters (7x6 total), PIX_DIV 1 and 3, with a queue scoreboard.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
        logic       de;
        logic       bn;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
        logic       pt;
    } obs_t;

    logic       clk;
    logic       rstn;
    logic       en;
    logic       restart;

    logic [2:0] x0, y0, x1, y1;
    logic       de0, bn0, hs0, vs0, ls0, fs0, pt0;
    logic       de1, bn1, hs1, vs1, ls1, fs1, pt1;
    obs_t       o0, o1;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc   = 0;

    int         mdiv[2];
    int         mh[2];
    int         mv[2];
    obs_t       mexp[2];
    obs_t       sb0[$];
    obs_t       sb1[$];
    obs_t       hist0[$];
    obs_t       hist1[$];

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIX_DIV(1)
    ) dut0 (
        .clk(clk), .resetn(rstn), .enable(en), .restart(restart),
        .x(x0), .y(y0), .de(de0), .blank_n(bn0), .hsync(hs0), .vsync(vs0),
        .line_start(ls0), .frame_start(fs0), .pix_tick(pt0)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIX_DIV(3)
    ) dut1 (
        .clk(clk), .resetn(rstn), .enable(en), .restart(restart),
        .x(x1), .y(y1), .de(de1), .blank_n(bn1), .hsync(hs1), .vsync(vs1),
        .line_start(ls1), .frame_start(fs1), .pix_tick(pt1)
    );

    assign o0 = {x0, y0, de0, bn0, hs0, vs0, ls0, fs0, pt0};
    assign o1 = {x1, y1, de1, bn1, hs1, vs1, ls1, fs1, pt1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t idle(input bit pol);
        obs_t o;
        o = '0;
        o.hs = ~pol;
        o.vs = ~pol;
        return o;
    endfunction

    // Raster 4/1/1/1 x 3/1/1/1: hsync at h==5, vsync on line 4.
    function automatic obs_t decode(input int h, input int v, input bit pol);
        obs_t o;
        o.x  = 3'(h);
        o.y  = 3'(v);
        o.de = (h < 4) && (v < 3);
        o.bn = o.de;
        o.hs = (h == 5) ? pol : ~pol;
        o.vs = (v == 4) ? pol : ~pol;
        o.ls = (h == 0);
        o.fs = (h == 0) && (v == 0);
        o.pt = 1'b1;
        return o;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mdiv[k] = 0;
            mh[k]   = 0;
            mv[k]   = 0;
            mexp[k] = idle(k == 1);
        end
    endtask

    task automatic model_edge(input int k, input bit en_i, input bit rs_i);
        int div;
        bit pol;
        div = (k == 0) ? 1 : 3;
        pol = (k == 1);
        if (rs_i) begin
            mdiv[k] = 0;
            mh[k]   = 0;
            mv[k]   = 0;
            mexp[k] = idle(pol);
        end else begin
            mexp[k].ls = 1'b0;
            mexp[k].fs = 1'b0;
            mexp[k].pt = 1'b0;
            if (en_i) begin
                if (mdiv[k] == div - 1) begin
                    mexp[k] = decode(mh[k], mv[k], pol);
                    mdiv[k] = 0;
                    mh[k]++;
                    if (mh[k] == 7) begin
                        mh[k] = 0;
                        mv[k] = (mv[k] + 1) % 6;
                    end
                end else begin
                    mdiv[k]++;
                end
            end
        end
    endtask

    task automatic cmp(input string tag, input obs_t o, input obs_t e);
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s @cyc %0d: observed x=%0d y=%0d de=%b bn=%b hs=%b vs=%b ls=%b fs=%b pt=%b, expected x=%0d y=%0d de=%b bn=%b hs=%b vs=%b ls=%b fs=%b pt=%b",
                   tag, cyc, o.x, o.y, o.de, o.bn, o.hs, o.vs, o.ls, o.fs, o.pt,
                   e.x, e.y, e.de, e.bn, e.hs, e.vs, e.ls, e.fs, e.pt);
        end
    endtask

    task automatic cmp_int(input string tag, input int o, input int e);
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, o, e);
        end
    endtask

    task automatic step(input bit en_i, input bit rs_i);
        obs_t e0, e1;
        en      = en_i;
        restart = rs_i;
        model_edge(0, en_i, rs_i);
        model_edge(1, en_i, rs_i);
        sb0.push_back(mexp[0]);
        sb1.push_back(mexp[1]);
        @(posedge clk);
        #1;
        cyc++;
        e0 = sb0.pop_front();
        e1 = sb1.pop_front();
        cmp("sb_div1", o0, e0);
        cmp("sb_div3", o1, e1);
    endtask

    task automatic run_until_fs0(input string tag, input int bound, output int t);
        bit found;
        found = 1'b0;
        t     = 0;
        for (int i = 0; i < bound && !found; i++) begin
            step(1'b1, 1'b0);
            if (o0.fs) begin
                found = 1'b1;
                t     = cyc;
            end
        end
        n_vec++;
        assert (found) else begin
            n_err++;
            $error("FAIL %s: observed no frame_start within %0d cycles, expected one", tag, bound);
        end
    endtask

    initial begin
        int fsi0[$];
        int fsi1[$];
        int cnt_a, cnt_b, cnt_c, cnt_d, cnt_e, cnt_f;
        int t0, t1;
        obs_t held;
        bit found;

        rstn    = 1'b1;
        en      = 1'b1;
        restart = 1'b0;
        #2 rstn = 1'b0;
        #1;
        cmp("reset_async_div1", o0, idle(1'b0));
        cmp("reset_async_div3", o1, idle(1'b1));
        @(posedge clk);
        @(posedge clk);
        #1;
        cmp("reset_hold_div1", o0, idle(1'b0));
        cmp("reset_hold_div3", o1, idle(1'b1));
        model_reset();
        #3 rstn = 1'b1;

        // Free-running frames.
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'b0);
            hist0.push_back(o0);
            hist1.push_back(o1);
        end
        cmp("first_tick_div1", hist0[0], decode(0, 0, 1'b0));
        cmp("first_tick_div3", hist1[2], decode(0, 0, 1'b1));
        for (int i = 0; i < 200; i++) begin
            if (hist0[i].fs) fsi0.push_back(i);
            if (hist1[i].fs) fsi1.push_back(i);
        end
        cmp_int("fs_count_div1", fsi0.size(), 5);
        cmp_int("fs_count_div3", fsi1.size(), 2);
        if (fsi0.size() >= 3 && fsi1.size() >= 2) begin
            cmp_int("frame_period_div1_a", fsi0[1] - fsi0[0], 42);
            cmp_int("frame_period_div1_b", fsi0[2] - fsi0[1], 42);
            cmp_int("frame_period_div3", fsi1[1] - fsi1[0], 126);
            cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0; cnt_e = 0; cnt_f = 0;
            for (int i = fsi0[0]; i < fsi0[1]; i++) begin
                if (hist0[i].ls) cnt_a++;
                if (hist0[i].de) cnt_b++;
                if (!hist0[i].hs) cnt_c++;
                if (!hist0[i].hs && hist0[i].x != 3'd5) cnt_d++;
                if (!hist0[i].vs) cnt_e++;
                if (!hist0[i].vs && hist0[i].y != 3'd4) cnt_f++;
            end
            cmp_int("lines_per_frame", cnt_a, 6);
            cmp_int("de_ticks_per_frame", cnt_b, 12);
            cmp_int("hsync_low_ticks", cnt_c, 6);
            cmp_int("hsync_low_off_x5", cnt_d, 0);
            cmp_int("vsync_low_ticks", cnt_e, 7);
            cmp_int("vsync_low_off_y4", cnt_f, 0);
            cnt_a = 0;
            for (int i = fsi1[0]; i < fsi1[1]; i++) begin
                if (hist1[i].hs) cnt_a++;
            end
            cmp_int("hsync_high_clks_div3", cnt_a, 18);
        end
        t0 = -1; cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 200; i++) begin
            if (hist0[i].ls) begin
                if (t0 >= 0 && i - t0 != 7) cnt_a++;
                t0 = i;
            end
            if (hist1[i].pt !== ((i % 3) == 2)) cnt_b++;
        end
        cmp_int("line_period_bad", cnt_a, 0);
        cmp_int("pix_tick_every3_bad", cnt_b, 0);

        // Enable dropped mid-line for 50 cycles.
        run_until_fs0("wait_fs_en_a", 100, t0);
        repeat (3) step(1'b1, 1'b0);
        held  = o0;
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b0);
            if (o0.x !== held.x || o0.y !== held.y || o0.de !== held.de) cnt_a++;
            if (o0.ls || o0.fs || o0.pt || o1.ls || o1.fs || o1.pt) cnt_b++;
        end
        cmp_int("enable_low_hold", cnt_a, 0);
        cmp_int("enable_low_strobes", cnt_b, 0);
        run_until_fs0("wait_fs_en_b", 200, t1);
        cmp_int("frame_period_stretched", t1 - t0, 92);

        // Restart mid-frame at (2,1).
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step(1'b1, 1'b0);
            if (o0.pt && o0.x == 3'd2 && o0.y == 3'd1) found = 1'b1;
        end
        n_vec++;
        assert (found) else begin
            n_err++;
            $error("FAIL wait_xy_2_1: observed no tick at (2,1) within 60 cycles, expected one");
        end
        step(1'b1, 1'b1);
        cmp("restart_idle", o0, idle(1'b0));
        step(1'b1, 1'b0);
        cmp("restart_first", o0, decode(0, 0, 1'b0));
        repeat (10) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        cmp("restart_disabled_idle", o0, idle(1'b0));
        step(1'b1, 1'b0);
        cmp("restart_disabled_first", o0, decode(0, 0, 1'b0));
        repeat (12) step(1'b1, 1'b0);

        // Asynchronous reset mid-frame.
        #3 rstn = 1'b0;
        #1;
        cmp("reset_mid_div1", o0, idle(1'b0));
        cmp("reset_mid_div3", o1, idle(1'b1));
        model_reset();
        #2 rstn = 1'b1;
        step(1'b1, 1'b0);
        cmp("post_reset_div1", o0, decode(0, 0, 1'b0));
        repeat (2) step(1'b1, 1'b0);
        cmp("post_reset_div3", o1, decode(0, 0, 1'b1));
        repeat (10) step(1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
